// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed 4-digit 7-segment driver.
// Scans one digit per SCAN_DIV cycles, decodes its BCD nibble, blanks blinking
// digits during the blanking half of the blink period and drives the HH:MM dot.
module display_scan_mux #(
  parameter int unsigned SCAN_DIV  = 256,
  parameter int unsigned BLINK_DIV = 16384
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [15:0] i_Bcd,
  input  logic [3:0]  i_Blink_En,
  input  logic        i_Blink_Sync,
  input  logic        i_Dot_En,
  output logic [7:0]  o_Segments,
  output logic [3:0]  o_Digits,
  output logic        o_Blink_Phase
);

  localparam int unsigned ScanW  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [ScanW-1:0]  scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        dig_q, dig_d;

  logic [3:0]        nibble;
  logic [6:0]        decoded;
  logic              blank;

  // Scan counter and digit index: index advances once per SCAN_DIV cycles.
  always_comb begin
    scan_d = scan_q + ScanW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanLast) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Blink timebase; a sync pulse restarts it in the visible phase.
  always_comb begin
    blink_d = blink_q + BlinkW'(1);
    phase_d = phase_q;
    if (i_Blink_Sync) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BlinkLast) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end
  end

  // Select the current digit's nibble and decode it to segments g..a.
  always_comb begin
    nibble = 4'h0;
    unique case (idx_q)
      2'd0: nibble = i_Bcd[3:0];
      2'd1: nibble = i_Bcd[7:4];
      2'd2: nibble = i_Bcd[11:8];
      2'd3: nibble = i_Bcd[15:12];
      default: nibble = 4'h0;
    endcase
    case (nibble)
      4'd0:    decoded = 7'h3F;
      4'd1:    decoded = 7'h06;
      4'd2:    decoded = 7'h5B;
      4'd3:    decoded = 7'h4F;
      4'd4:    decoded = 7'h66;
      4'd5:    decoded = 7'h6D;
      4'd6:    decoded = 7'h7D;
      4'd7:    decoded = 7'h07;
      4'd8:    decoded = 7'h7F;
      4'd9:    decoded = 7'h6F;
      // Non-BCD nibbles show as a dark digit.
      default: decoded = 7'h00;
    endcase
  end

  // Next output word: blanked digits drive neither enable nor segments.
  always_comb begin
    blank = i_Blink_En[idx_q] & phase_q;
    dig_d = 4'b0001 << idx_q;
    seg_d = {i_Dot_En & (idx_q == 2'd2), decoded};
    if (blank) begin
      dig_d = 4'b0000;
      seg_d = 8'h00;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      scan_q  <= '0;
      idx_q   <= 2'd0;
      blink_q <= '0;
      phase_q <= 1'b0;
      seg_q   <= 8'h00;
      dig_q   <= 4'b0000;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign o_Segments    = seg_q;
  assign o_Digits      = dig_q;
  assign o_Blink_Phase = phase_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux with short scan/blink periods.
module tb_display_scan_mux;

  localparam int unsigned SD = 4;
  localparam int unsigned BD = 32;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic [15:0] i_Bcd = 16'h0000;
  logic [3:0]  i_Blink_En = 4'b0000;
  logic        i_Blink_Sync = 1'b0;
  logic        i_Dot_En = 1'b0;
  logic [7:0]  o_Segments;
  logic [3:0]  o_Digits;
  logic        o_Blink_Phase;

  display_scan_mux #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Bcd        (i_Bcd),
    .i_Blink_En   (i_Blink_En),
    .i_Blink_Sync (i_Blink_Sync),
    .i_Dot_En     (i_Dot_En),
    .o_Segments   (o_Segments),
    .o_Digits     (o_Digits),
    .o_Blink_Phase(o_Blink_Phase)
  );

  always #5 i_Clock = ~i_Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int          m_scan, m_idx, m_bcnt;
  logic        m_phase;
  logic [12:0] sb[$];
  logic [6:0]  dec_tab[16];

  initial begin
    dec_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  end

  // Push the expected post-edge outputs, advance the model, clock once.
  task automatic step();
    logic [3:0] nib;
    logic       blk;
    logic [3:0] ed;
    logic [7:0] es;
    nib = 4'((i_Bcd >> (m_idx * 4)) & 16'hF);
    blk = i_Blink_En[m_idx] && m_phase;
    ed  = blk ? 4'b0000 : 4'(1 << m_idx);
    es  = blk ? 8'h00 : {(i_Dot_En && m_idx == 2), dec_tab[nib]};
    if (m_scan == SD - 1) begin
      m_scan = 0;
      m_idx  = (m_idx + 1) % 4;
    end else m_scan++;
    if (i_Blink_Sync) begin
      m_bcnt = 0; m_phase = 1'b0;
    end else if (m_bcnt == BD - 1) begin
      m_bcnt = 0; m_phase = ~m_phase;
    end else m_bcnt++;
    sb.push_back({es, ed, m_phase});
    @(posedge i_Clock);
    #1;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    m_scan = 0; m_idx = 0; m_bcnt = 0; m_phase = 1'b0;
    sb.delete();
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
  endtask

  task automatic test_reset();
    i_Bcd = 16'h1234; i_Blink_En = 4'b0000; i_Dot_En = 1'b0;
    do_reset();
    n_checks++;
    if ({o_Segments, o_Digits, o_Blink_Phase} !== 13'h0)
      $display("FAIL reset_state got=%h want=0", {o_Segments, o_Digits, o_Blink_Phase});
    else n_pass++;
  endtask

  task automatic test_scan();
    logic [12:0] e;
    logic [7:0] seg_tab[4];
    seg_tab = '{8'h66, 8'h4F, 8'h5B, 8'h06};
    i_Bcd = 16'h1234;
    do_reset();
    for (int k = 0; k < 8 * SD; k++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({o_Segments, o_Digits, o_Blink_Phase} !== e)
        $display("FAIL scan_sb k=%0d got=%h want=%h", k,
                 {o_Segments, o_Digits, o_Blink_Phase}, e);
      else n_pass++;
      n_checks++;
      if (o_Digits !== 4'(1 << ((k / SD) % 4)) || o_Segments !== seg_tab[(k / SD) % 4])
        $display("FAIL scan_slot k=%0d dig=%b seg=%h want_dig=%b want_seg=%h", k,
                 o_Digits, o_Segments, 4'(1 << ((k / SD) % 4)), seg_tab[(k / SD) % 4]);
      else n_pass++;
    end
  endtask

  task automatic test_dot();
    logic [12:0] e;
    i_Bcd = 16'h2359;
    for (int pass = 0; pass < 2; pass++) begin
      i_Dot_En = (pass == 0);
      for (int k = 0; k < 4 * SD; k++) begin
        step();
        e = sb.pop_front();
        n_checks++;
        if ({o_Segments, o_Digits, o_Blink_Phase} !== e)
          $display("FAIL dot_sb got=%h want=%h", {o_Segments, o_Digits, o_Blink_Phase}, e);
        else n_pass++;
        n_checks++;
        if (o_Segments[7] !== (i_Dot_En && o_Digits == 4'b0100))
          $display("FAIL dot_bit en=%b dig=%b got=%b", i_Dot_En, o_Digits, o_Segments[7]);
        else n_pass++;
      end
    end
    i_Dot_En = 1'b0;
  endtask

  task automatic test_blink();
    logic [12:0] e;
    int zeros;
    i_Bcd = 16'h0959; i_Blink_En = 4'b0011;
    do_reset();
    zeros = 0;
    for (int k = 0; k < 4 * BD; k++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({o_Segments, o_Digits, o_Blink_Phase} !== e)
        $display("FAIL blink_sb k=%0d got=%h want=%h", k, {o_Segments, o_Digits, o_Blink_Phase}, e);
      else n_pass++;
      if (o_Digits == 4'b0000) zeros++;
      n_checks++;
      if (o_Digits == 4'b0000 && o_Segments !== 8'h00)
        $display("FAIL blink_blank_seg got=%h want=00", o_Segments);
      else n_pass++;
    end
    // Two blanking halves, digits 0-1 occupy half of each.
    n_checks++;
    if (zeros != BD) $display("FAIL blink_count got=%0d want=%0d", zeros, BD);
    else n_pass++;
  endtask

  task automatic test_sync();
    logic [12:0] e;
    int n;
    i_Bcd = 16'h1200; i_Blink_En = 4'b1111;
    do_reset();
    n = 0;
    while (o_Blink_Phase !== 1'b1 && n < 2 * BD) begin
      step(); void'(sb.pop_front()); n++;
    end
    n_checks++;
    if (o_Blink_Phase !== 1'b1) $display("FAIL sync_reach_blank timeout phase=%b", o_Blink_Phase);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin step(); void'(sb.pop_front()); end
    i_Blink_Sync = 1'b1;
    step();
    i_Blink_Sync = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({o_Segments, o_Digits, o_Blink_Phase} !== e || o_Blink_Phase !== 1'b0)
      $display("FAIL sync_phase got=%h want=%h", {o_Segments, o_Digits, o_Blink_Phase}, e);
    else n_pass++;
    n = 0;
    while (o_Blink_Phase !== 1'b1 && n < 2 * BD) begin
      step();
      e = sb.pop_front();
      n++;
      n_checks++;
      if ({o_Segments, o_Digits, o_Blink_Phase} !== e)
        $display("FAIL sync_sb got=%h want=%h", {o_Segments, o_Digits, o_Blink_Phase}, e);
      else n_pass++;
    end
    n_checks++;
    if (n != BD) $display("FAIL sync_period got=%0d want=%0d", n, BD);
    else n_pass++;
    i_Blink_En = 4'b0000;
  endtask

  task automatic test_nonbcd();
    logic [12:0] e;
    i_Bcd = 16'hFACB; i_Blink_En = 4'b0000;
    for (int k = 0; k < 4 * SD; k++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({o_Segments, o_Digits, o_Blink_Phase} !== e || o_Segments[6:0] !== 7'h00
          || !$onehot(o_Digits))
        $display("FAIL nonbcd got_seg=%h got_dig=%b want=%h", o_Segments, o_Digits, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    i_Bcd = 16'h1234; i_Blink_En = 4'b0000;
    do_reset();
    for (int k = 0; k < 2 * SD + 2; k++) begin step(); void'(sb.pop_front()); end
    n_checks++;
    if (o_Digits !== 4'b0100) $display("FAIL mid_pre dig=%b want=0100", o_Digits);
    else n_pass++;
    #2;
    i_Reset = 1'b1;
    #1;
    n_checks++;
    if (o_Segments !== 8'h00 || o_Digits !== 4'b0000)
      $display("FAIL mid_async seg=%h dig=%b want 00/0000", o_Segments, o_Digits);
    else n_pass++;
    m_scan = 0; m_idx = 0; m_bcnt = 0; m_phase = 1'b0;
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    for (int k = 0; k < SD + 1; k++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({o_Segments, o_Digits, o_Blink_Phase} !== e ||
          o_Digits !== ((k < SD) ? 4'b0001 : 4'b0010))
        $display("FAIL mid_resume k=%0d got=%h want=%h", k, {o_Segments, o_Digits, o_Blink_Phase}, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_dot();
    test_blink();
    test_sync();
    test_nonbcd();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
